// File: rtl/trng_pkg.sv
// Shared defaults and types for the ring-oscillator
// random-word collector.
package trng_pkg;

   localparam int TRNG_WIDTH      = 32;
   localparam int TRNG_NUM_SRC    = 3;
   localparam int TRNG_SYNC       = 2;
   localparam int TRNG_DEBIAS     = 1;
   localparam int TRNG_RCT_CUTOFF = 32;
   localparam int TRNG_FIFO_DEPTH = 4;

   typedef enum logic {
      WAIT_FIRST,
      WAIT_SECOND
   } vn_state_t;

endpackage

// File: rtl/vn_corrector.sv
// Von Neumann debiaser on the synchronised bit;
// DEBIAS=0 passes every bit straight through.
module vn_corrector
   import trng_pkg::*;
#(
   parameter int DEBIAS = TRNG_DEBIAS
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s_bit,
   output logic bit_out,
   output logic bit_valid
);

   vn_state_t state;
   logic      first;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state     <= WAIT_FIRST;
         first     <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else if (DEBIAS == 0) begin
         bit_out   <= s_bit;
         bit_valid <= 1'b1;
      end else begin
         unique case (state)
            WAIT_FIRST: begin
               first     <= s_bit;
               state     <= WAIT_SECOND;
               bit_valid <= 1'b0;
            end
            WAIT_SECOND: begin
               bit_out   <= first;
               bit_valid <= (s_bit != first);
               state     <= WAIT_FIRST;
            end
            default: begin
               state     <= WAIT_FIRST;
               bit_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/trng_collector.sv
// Combines ring-oscillator bits into random words with a
// repetition-count health test and a registered-head FIFO.
module trng_collector
   import trng_pkg::*;
#(
   parameter int WIDTH       = TRNG_WIDTH,
   parameter int NUM_SRC     = TRNG_NUM_SRC,
   parameter int SYNC_STAGES = TRNG_SYNC,
   parameter int DEBIAS      = TRNG_DEBIAS,
   parameter int RCT_CUTOFF  = TRNG_RCT_CUTOFF,
   parameter int FIFO_DEPTH  = TRNG_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_SRC-1:0] ring_in,
   output logic [WIDTH-1:0]   rnd_data,
   output logic               rnd_valid,
   input  logic               rnd_ready,
   output logic               health_fail,
   output logic               overflow
);

   localparam int BW = $clog2(WIDTH);
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_bit;
   logic                   vn_bit;
   logic                   vn_valid;
   logic [WIDTH-2:0]       acc;
   logic [BW-1:0]          bcnt;
   logic [RW-1:0]          rct_cnt;
   logic                   rct_prev;
   logic [WIDTH-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [CW-1:0]          count;

   logic                   word_done;
   logic                   trip;
   logic                   fail_n;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic [WIDTH-1:0]       word;
   logic [WIDTH-1:0]       head;
   logic [AW-1:0]          rd_n;
   logic [CW-1:0]          left;
   logic [CW-1:0]          cnt_n;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], ^ring_in};
   end

   assign s_bit = sync_q[SYNC_STAGES-1];

   vn_corrector #(
      .DEBIAS(DEBIAS)
   ) u_vn (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .s_bit    (s_bit),
      .bit_out  (vn_bit),
      .bit_valid(vn_valid)
   );

   // The head register is loaded with the word that will be at
   // the head after this cycle, bypassing mem when it is the push.
   always_comb begin
      word      = {acc, vn_bit};
      word_done = en && vn_valid && (bcnt == BW'(WIDTH - 1));
      trip      = en && (rct_cnt == RW'(RCT_CUTOFF - 1))
                  && (s_bit == rct_prev);
      fail_n    = health_fail || trip;
      pop       = rnd_valid && rnd_ready;
      left      = count - CW'(pop);
      push      = word_done && !fail_n && (left != CW'(FIFO_DEPTH));
      drop      = word_done && !fail_n && (left == CW'(FIFO_DEPTH));
      rd_n      = rd_ptr + AW'(pop);
      cnt_n     = left + CW'(push);
      head      = (push && left == '0) ? word : mem[rd_n];
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         rct_cnt  <= '0;
         rct_prev <= 1'b0;
      end else begin
         rct_prev <= s_bit;
         if (rct_cnt == '0 || s_bit != rct_prev)
            rct_cnt <= RW'(1);
         else if (rct_cnt != RW'(RCT_CUTOFF))
            rct_cnt <= rct_cnt + RW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en || trip) begin
         acc  <= '0;
         bcnt <= '0;
      end else if (vn_valid) begin
         acc  <= word[WIDTH-2:0];
         bcnt <= word_done ? '0 : bcnt + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rnd_valid   <= 1'b0;
         rnd_data    <= '0;
         health_fail <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (trip) health_fail <= 1'b1;
         if (drop) overflow    <= 1'b1;
         if (fail_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rnd_valid <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_n;
            count     <= cnt_n;
            rnd_valid <= (cnt_n != '0);
            if (cnt_n != '0) rnd_data <= head;
         end
      end
   end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench: raw 8-bit instance plus a debiased
// 4-bit instance.
module tb_trng_collector;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, rnd_ready;
   logic [2:0] ring_in;
   logic [7:0] rnd_data;
   logic       rnd_valid, health_fail, overflow;

   logic       rst_b, en_b, rnd_ready_b;
   logic [2:0] ring_in_b;
   logic [3:0] rnd_data_b;
   logic       rnd_valid_b, health_fail_b, overflow_b;

   int tests = 0;
   int fails = 0;

   trng_collector #(
      .WIDTH(8), .NUM_SRC(3), .SYNC_STAGES(2), .DEBIAS(0),
      .RCT_CUTOFF(32), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ring_in(ring_in),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid),
      .rnd_ready(rnd_ready), .health_fail(health_fail),
      .overflow(overflow)
   );

   trng_collector #(
      .WIDTH(4), .NUM_SRC(3), .SYNC_STAGES(2), .DEBIAS(1),
      .RCT_CUTOFF(32), .FIFO_DEPTH(4)
   ) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .ring_in(ring_in_b),
      .rnd_data(rnd_data_b), .rnd_valid(rnd_valid_b),
      .rnd_ready(rnd_ready_b), .health_fail(health_fail_b),
      .overflow(overflow_b)
   );

   // Bit i (MSB first) is sampled at edge i+3; en covers those
   // samples plus the push edge, then drops.
   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ring_in[0] = (i < 8) ? w[7-i] : 1'b0;
         en = (i >= 2 && i <= 10);
      end
   endtask

   task automatic send_b(input logic [11:0] seq);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ring_in_b[0] = (i < 12) ? seq[11-i] : 1'b0;
         en_b = (i >= 2 && i <= 14);
      end
   endtask

   task automatic send_partial(input logic [7:0] w);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         ring_in[0] = w[7-i];
         en = (i >= 2);
      end
   endtask

   task automatic pulse_rst;
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rnd_valid); end
      tests++; if (rnd_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", rnd_data); end
      tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL reset_health got %b exp 0", health_fail); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
   endtask

   task automatic test_basic;
      pulse_rst();
      rnd_ready = 1'b1;
      send_word(8'hA5);
      tests++; if (rnd_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", rnd_valid); end
      tests++; if (rnd_data !== 8'hA5) begin fails++; $display("FAIL basic_data got %h exp a5", rnd_data); end
      @(negedge clk);
      tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL basic_popped got %b exp 0", rnd_valid); end
      send_word(8'h3C);
      tests++; if (rnd_data !== 8'h3C) begin fails++; $display("FAIL basic_data2 got %h exp 3c", rnd_data); end
      tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL basic_health got %b exp 0", health_fail); end
   endtask

   task automatic test_xor;
      ring_in[2:1] = 2'b11;
      send_word(8'hA5);
      tests++; if (rnd_valid !== 1'b1) begin fails++; $display("FAIL xor_valid got %b exp 1", rnd_valid); end
      tests++; if (rnd_data !== 8'hA5) begin fails++; $display("FAIL xor_data got %h exp a5", rnd_data); end
      ring_in[2:1] = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [7:0] exp_w [4];
      exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
      pulse_rst();
      rnd_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send_word(exp_w[k]);
         tests++; if (rnd_data !== 8'h11 || rnd_valid !== 1'b1) begin fails++; $display("FAIL bp_stall%0d got %h/%b exp 11/1", k, rnd_data, rnd_valid); end
      end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_no_ovf got %b exp 0", overflow); end
      send_word(8'h55);
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_ovf got %b exp 1", overflow); end
      tests++; if (rnd_data !== 8'h11) begin fails++; $display("FAIL bp_head got %h exp 11", rnd_data); end
      rnd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tests++; if (rnd_valid !== 1'b1 || rnd_data !== exp_w[k]) begin fails++; $display("FAIL bp_drain%0d got %h/%b exp %h/1", k, rnd_data, rnd_valid, exp_w[k]); end
         @(negedge clk);
      end
      tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", rnd_valid); end
   endtask

   task automatic test_rct;
      int fail_at;
      fail_at = -1;
      pulse_rst();
      rnd_ready = 1'b0;
      send_word(8'h5A);
      send_word(8'hC3);
      tests++; if (rnd_valid !== 1'b1) begin fails++; $display("FAIL rct_pre_valid got %b exp 1", rnd_valid); end
      @(negedge clk);
      ring_in = 3'b000;
      en = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (health_fail && fail_at < 0) fail_at = i;
      end
      tests++; if (fail_at != 32) begin fails++; $display("FAIL rct_cycle got %0d exp 32", fail_at); end
      tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL rct_flush got %b exp 0", rnd_valid); end
      en = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      tests++; if (health_fail !== 1'b1) begin fails++; $display("FAIL rct_sticky got %b exp 1", health_fail); end
      pulse_rst();
      tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL rct_rst got %b exp 0", health_fail); end
   endtask

   task automatic test_mid_word;
      pulse_rst();
      rnd_ready = 1'b0;
      send_word(8'h96);
      send_partial(8'hF0);
      pulse_rst();
      tests++; if (rnd_valid !== 1'b0 || rnd_data !== 8'h00) begin fails++; $display("FAIL mid_rst_out got %h/%b exp 00/0", rnd_data, rnd_valid); end
      tests++; if (overflow !== 1'b0 || health_fail !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got %b/%b exp 0/0", overflow, health_fail); end
      send_word(8'h96);
      send_partial(8'hF0);
      @(negedge clk);
      en = 1'b0;
      send_word(8'h3C);
      tests++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h96) begin fails++; $display("FAIL mid_en_keep got %h/%b exp 96/1", rnd_data, rnd_valid); end
      rnd_ready = 1'b1;
      @(negedge clk);
      tests++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h3C) begin fails++; $display("FAIL mid_en_next got %h/%b exp 3c/1", rnd_data, rnd_valid); end
      @(negedge clk);
      tests++; if (rnd_valid !== 1'b0) begin fails++; $display("FAIL mid_en_empty got %b exp 0", rnd_valid); end
   endtask

   task automatic test_debias;
      @(negedge clk);
      rst_b = 1'b0;
      send_b(12'b0110_0011_1001);
      tests++; if (rnd_valid_b !== 1'b1) begin fails++; $display("FAIL vn_valid got %b exp 1", rnd_valid_b); end
      tests++; if (rnd_data_b !== 4'h6) begin fails++; $display("FAIL vn_data got %h exp 6", rnd_data_b); end
      tests++; if (health_fail_b !== 1'b0 || overflow_b !== 1'b0) begin fails++; $display("FAIL vn_flags got %b/%b exp 0/0", health_fail_b, overflow_b); end
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      rnd_ready = 1'b0;
      ring_in = 3'b000;
      rst_b = 1'b1;
      en_b = 1'b0;
      rnd_ready_b = 1'b0;
      ring_in_b = 3'b000;
      test_reset();
      test_basic();
      test_xor();
      test_backpressure();
      test_rct();
      test_mid_word();
      test_debias();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
